// File: rtl/capture_packer_if.sv
// capture_packer_if
//   Groups the sample stream, FIFO handshake and monitor statistics of the
//   capture packer into one bundle.
//   master : sample source / FIFO side (drives enable, s_valid, s_data,
//            s_last, fifo_full; observes the packer outputs)
//   slave  : the packer itself (drives wr_en, data_in, lane_fill,
//            word_count, drop_count, busy)
interface capture_packer_if #(
  parameter int IN_WIDTH  = 64,
  parameter int OUT_WIDTH = 512
);
  logic                 enable;
  logic                 s_valid;
  logic [IN_WIDTH-1:0]  s_data;
  logic                 s_last;
  logic                 fifo_full;
  logic                 wr_en;
  logic [OUT_WIDTH-1:0] data_in;
  logic [7:0]           lane_fill;
  logic [31:0]          word_count;
  logic [31:0]          drop_count;
  logic                 busy;

  modport master (
    output enable, s_valid, s_data, s_last, fifo_full,
    input  wr_en, data_in, lane_fill, word_count, drop_count, busy
  );

  modport slave (
    input  enable, s_valid, s_data, s_last, fifo_full,
    output wr_en, data_in, lane_fill, word_count, drop_count, busy
  );
endinterface

// File: rtl/capture_packer.sv
// capture_packer
//   Write-side feeder for the dual-clock capture FIFO (wr_clk domain only).
//   Packs LANES consecutive IN_WIDTH samples into one OUT_WIDTH word, lane 0
//   in the low bits, and issues a registered one-cycle wr_en with data_in.
//   Partial words are flushed on s_last, on idle timeout or when enable drops.
//   Ports:
//     wr_clk  - clock
//     reset   - synchronous, active-high
//     bus     - capture_packer_if.slave: sample stream in, FIFO write strobe
//               and data out, lane_fill / word_count / drop_count / busy
module capture_packer #(
  parameter int IN_WIDTH     = 64,
  parameter int OUT_WIDTH    = 512,
  parameter int TIMEOUT      = 256,
  parameter int DROP_ON_FULL = 1
) (
  input  logic             wr_clk,
  input  logic             reset,
  capture_packer_if.slave  bus
);

  localparam int LANES  = OUT_WIDTH / IN_WIDTH;
  localparam int IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_FILLING = 2'd1;
  localparam logic [1:0] ST_EMIT    = 2'd2;

  logic [1:0]           r_state;
  logic [OUT_WIDTH-1:0] r_buf;
  logic [7:0]           r_fill;
  logic [IDLE_W-1:0]    r_idle;
  logic                 r_wr_en;
  logic [OUT_WIDTH-1:0] r_data;
  logic [31:0]          r_word_cnt;
  logic [31:0]          r_drop_cnt;

  logic                 w_accept;
  logic                 w_timeout;
  logic                 w_close;
  logic [OUT_WIDTH-1:0] w_word;

  assign w_accept  = bus.enable && bus.s_valid;
  // The idle counter holds TIMEOUT-1 during the last idle cycle, so the
  // closing edge is the TIMEOUT-th idle edge; a sample on that edge wins.
  assign w_timeout = (TIMEOUT != 0) && (r_idle == IDLE_LAST);
  assign w_close   = w_accept ? ((r_fill == 8'(LANES - 1)) || bus.s_last)
                              : ((r_fill != '0) && (!bus.enable || w_timeout));

  // Current buffer with the accepted sample merged into its lane; this is
  // both the next buffer contents and the word written on close.
  always_comb begin
    w_word = r_buf;
    if (w_accept) begin
      for (int unsigned k = 0; k < LANES; k++) begin
        if (r_fill == 8'(k)) w_word[k*IN_WIDTH +: IN_WIDTH] = bus.s_data;
      end
    end
  end

  always_ff @(posedge wr_clk) begin
    if (reset) begin
      r_state    <= ST_EMPTY;
      r_buf      <= '0;
      r_fill     <= '0;
      r_idle     <= '0;
      r_wr_en    <= 1'b0;
      r_data     <= '0;
      r_word_cnt <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_wr_en <= 1'b0;
      if (w_close) begin
        r_state <= ST_EMIT;
        r_buf   <= '0;
        r_fill  <= '0;
        r_idle  <= '0;
        if (bus.fifo_full && (DROP_ON_FULL != 0)) begin
          if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 32'd1;
        end else begin
          r_wr_en <= 1'b1;
          r_data  <= w_word;
          if (r_word_cnt != '1) r_word_cnt <= r_word_cnt + 32'd1;
          if (bus.fifo_full && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + 32'd1;
        end
      end else if (w_accept) begin
        r_state <= ST_FILLING;
        r_buf   <= w_word;
        r_fill  <= r_fill + 8'd1;
        r_idle  <= '0;
      end else begin
        r_state <= (r_fill != '0) ? ST_FILLING : ST_EMPTY;
        if ((r_fill != '0) && (TIMEOUT != 0)) r_idle <= r_idle + IDLE_W'(1);
      end
    end
  end

  assign bus.wr_en      = r_wr_en;
  assign bus.data_in    = r_data;
  assign bus.lane_fill  = r_fill;
  assign bus.word_count = r_word_cnt;
  assign bus.drop_count = r_drop_cnt;
  assign bus.busy       = (r_fill != '0) || (r_state == ST_EMIT);

endmodule

// File: doc/capture_packer.md
Name: capture_packer

Overview:
- Write-side feeder for the dual-clock capture FIFO, running entirely in the wr_clk domain.
- Accepts a stream of narrow samples, packs LANES consecutive samples into one FIFO-width word, and issues single-cycle wr_en pulses with data_in.
- Flushes partial words on s_last, on idle timeout, or on enable deassertion.
- Handles fifo_full according to policy and keeps saturating statistics for the monitor path.

Parameters:
- IN_WIDTH, 64, sample width in bits.
- OUT_WIDTH, 512, FIFO word width; must equal the FIFO WIDTH and be an integer multiple of IN_WIDTH.
- LANES, OUT_WIDTH/IN_WIDTH (derived, 8), samples per word; must be ≥2.
- TIMEOUT, 256, idle cycles before a partial word is flushed; 0 disables the timeout.
- DROP_ON_FULL, 1, 1 = suppress wr_en while fifo_full and count a drop; 0 = write anyway (FIFO overwrites) and count an overrun.

Ports:
- wr_clk  input  1  clock; everything is synchronous to it.
- reset  input  1  synchronous, active-high.
- enable  input  1  capture enable; samples are ignored when low.
- s_valid  input  1  sample strobe; no backpressure, every strobe with enable=1 is accepted.
- s_data  input  IN_WIDTH  sample data.
- s_last  input  1  qualifies s_valid; closes the current word after this sample.
- fifo_full  input  1  full flag from the FIFO.
- wr_en  output  1  registered one-cycle write strobe to the FIFO.
- data_in  output  OUT_WIDTH  registered packed word, valid while wr_en=1.
- lane_fill  output  8  number of samples held in the current partial word.
- word_count  output  32  words presented to the FIFO (wr_en pulses); saturates at 0xFFFFFFFF.
- drop_count  output  32  words dropped (DROP_ON_FULL=1) or overrun (DROP_ON_FULL=0); saturating.
- busy  output  1  high while lane_fill≠0 or a flush is pending.

Behaviour:
- Reset values: wr_en=0, data_in=0, lane_fill=0, word_count=0, drop_count=0, busy=0, idle counter=0, pack buffer cleared.
- Reset mid-word discards the partial word with no wr_en; reset has priority over all other events.
- Lane order: first sample of a word in bits [IN_WIDTH-1:0], sample k in bits [(k+1)*IN_WIDTH-1 : k*IN_WIDTH]. Unfilled lanes are zero.
- States:
  - EMPTY (lane_fill=0).
  - FILLING (0<lane_fill<LANES).
  - EMIT (internal one-cycle state, entered when a word closes).
- Transitions:
  - EMPTY→FILLING on an accepted sample without s_last.
  - EMPTY→EMIT on an accepted sample with s_last (1-lane word).
  - FILLING→EMIT when the LANES-th sample is accepted, on s_last, on timeout, or on enable falling.
  - EMIT→EMPTY or FILLING: a sample accepted in the EMIT cycle starts the next word at lane 0. There are no bubbles, so back-to-back words at one sample per cycle are sustained.
- Latency: wr_en and data_in are asserted exactly 1 cycle after the cycle in which the word closes.
- Timeout:
  - The idle counter increments each cycle while FILLING with no accepted sample, and clears on any accepted sample.
  - Reaching TIMEOUT closes the word.
  - If a sample arrives in the same cycle the counter reaches TIMEOUT, the sample is accepted and no flush occurs.
- Enable:
  - enable low: s_valid is ignored.
  - Falling enable with lane_fill>0 closes the partial word in that cycle.
  - Falling enable with lane_fill=0 does nothing.
- Full handling (fifo_full is sampled in the close cycle):
  - DROP_ON_FULL=1 and full: no wr_en; drop_count+1; word_count unchanged.
  - DROP_ON_FULL=0 and full: wr_en asserted; word_count+1 and drop_count+1.
  - Not full: wr_en asserted; word_count+1.
- Counters saturate at all-ones and never wrap.
- lane_fill and busy are updated in the same cycle as the accepting edge. busy stays high through the EMIT cycle.

Test Plan:
- Full word: enable=1, 8 consecutive samples 0x1..0x8, fifo_full=0 -> one wr_en pulse 1 cycle after the 8th sample; data_in lane0=0x1 … lane7=0x8; word_count=1.
- Back-to-back: 24 samples, one per cycle -> exactly 3 wr_en pulses 8 cycles apart; no sample lost; word_count=3.
- Partial flushes:
  - 3 samples with s_last on the 3rd -> wr_en 1 cycle later; lanes0-2 hold the data, lanes3-7=0.
  - 2 samples then idle, TIMEOUT=256 -> flush 256 idle cycles after the last sample.
  - Same as above but a sample arrives at idle=256 -> no flush; lane_fill=3.
- Full policy:
  - fifo_full=1 with 8 samples, DROP_ON_FULL=1 -> no wr_en; drop_count=1; word_count=0.
  - Same with DROP_ON_FULL=0 -> wr_en asserted; both counters=1.
- Enable/reset:
  - enable deasserted after 5 samples -> partial word emitted, 5 lanes filled.
  - reset asserted after 5 samples -> no wr_en; all outputs return to 0; the next 8 samples form a clean word.
- Saturation: preload via force or long run to word_count=0xFFFFFFFE, emit 3 words -> word_count holds 0xFFFFFFFF.
